// File: rtl/sample_capture_memory.sv
// sample_capture_memory
//
// Writer side of the 128 x 10-bit sample memory. Accepts samples over a
// valid/ready handshake, keeps one of every DECIMATION accepted samples and
// stores a capture of CAPTURE_LEN samples. The array is read back through a
// registered 1-cycle-latency port with no enable.
//
// Optional feature macro: CAPTURE_WRAP_EN
//   undefined : capture ends by length (CAPTURE_LEN stored samples -> DONE)
//   defined   : capture runs as a circular buffer until abort; write_count
//               saturates at 128 and abort lands in DONE if anything was stored
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no capture; waiting for start
// RECORD  | accepting samples, writing every DECIMATION-th one
// DONE    | capture complete; write_count / write_ptr held for readout

module sample_capture_memory #(
    parameter int CAPTURE_LEN = 128,
    parameter int DECIMATION  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       sample_valid,
    input  logic [9:0] sample_data,
    output logic       sample_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] write_count,
    output logic [6:0] write_ptr,
    input  logic [6:0] read_address,
    output logic [9:0] read_data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECORD = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int               DEC_W    = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIMATION - 1);
    localparam logic [7:0]       LEN_VAL  = 8'(CAPTURE_LEN);
    localparam logic [7:0]       FULL_CNT = 8'd128;

    logic [1:0]       r_state;
    logic [6:0]       r_write_ptr;
    logic [7:0]       r_write_count;
    logic [DEC_W-1:0] r_dec_cnt;
    logic [9:0]       r_read_data;
    logic [9:0]       r_mem [0:127];

    logic       w_recording;
    logic       w_accept;
    logic       w_dec_hit;
    logic       w_store;
    logic [7:0] w_count_inc;

    assign w_recording = (r_state == ST_RECORD);
    assign w_accept    = sample_valid && w_recording;
    assign w_dec_hit   = (r_dec_cnt == DEC_LAST);
    // Abort and reset both win over a same-cycle write.
    assign w_store     = rst_n && w_accept && !abort && w_dec_hit;
    assign w_count_inc = r_write_count + 8'd1;

    // Capture state, write pointer, stored-sample count and decimation phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_write_ptr   <= 7'd0;
            r_write_count <= 8'd0;
            r_dec_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_state       <= ST_RECORD;
                        r_write_ptr   <= 7'd0;
                        r_write_count <= 8'd0;
                        r_dec_cnt     <= '0;
                    end
                end
                ST_RECORD: begin
                    if (abort) begin
`ifdef CAPTURE_WRAP_EN
                        r_state <= (r_write_count != 8'd0) ? ST_DONE : ST_IDLE;
`else
                        r_state <= ST_IDLE;
`endif
                    end else if (sample_valid) begin
                        if (w_dec_hit) begin
                            r_dec_cnt   <= '0;
                            r_write_ptr <= r_write_ptr + 7'd1;
`ifdef CAPTURE_WRAP_EN
                            if (r_write_count != FULL_CNT) begin
                                r_write_count <= w_count_inc;
                            end
`else
                            r_write_count <= w_count_inc;
                            if (w_count_inc == LEN_VAL) begin
                                r_state <= ST_DONE;
                            end
`endif
                        end else begin
                            r_dec_cnt <= r_dec_cnt + DEC_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (start) begin
                        r_state       <= ST_RECORD;
                        r_write_ptr   <= 7'd0;
                        r_write_count <= 8'd0;
                        r_dec_cnt     <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sample array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_write_ptr] <= sample_data;
        end
    end

    // Registered readback; a same-address write this cycle is not visible yet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_read_data <= 10'd0;
        end else begin
            r_read_data <= r_mem[read_address];
        end
    end

    assign sample_ready = w_recording;
    assign busy         = w_recording;
    assign done         = (r_state == ST_DONE);
    assign write_count  = r_write_count;
    assign write_ptr    = r_write_ptr;
    assign read_data    = r_read_data;

endmodule

// File: tb/tb_sample_capture_memory.sv
// Testbench for sample_capture_memory: two instances (default parameters and
// CAPTURE_LEN=4 / DECIMATION=3) share stimulus. A capture-level reference
// model pushes expected outputs into a scoreboard queue; a monitor on the
// falling edge pops and compares them.

module tb_sample_capture_memory;

`ifdef CAPTURE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sample_valid = 1'b0;
    logic [9:0] sample_data = 10'd0;
    logic [6:0] read_address = 7'd0;

    logic       ready_a, busy_a, done_a, ready_b, busy_b, done_b;
    logic [7:0] cnt_a, cnt_b;
    logic [6:0] ptr_a, ptr_b;
    logic [9:0] rd_a, rd_b;

    always #5 clk = ~clk;

    sample_capture_memory u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(ready_a), .busy(busy_a), .done(done_a),
        .write_count(cnt_a), .write_ptr(ptr_a),
        .read_address(read_address), .read_data(rd_a)
    );

    sample_capture_memory #(.CAPTURE_LEN(4), .DECIMATION(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(ready_b), .busy(busy_b), .done(done_b),
        .write_count(cnt_b), .write_ptr(ptr_b),
        .read_address(read_address), .read_data(rd_b)
    );

    typedef struct {
        int due;
        int id;
        int exp;
    } item_t;

    item_t sb[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: a capture is a list of stored samples; counts and
    // pointer follow from how many samples have been stored.
    int m_len[2] = '{128, 4};
    int m_dec[2] = '{1, 3};
    int m_mode[2];      // 0 idle, 1 recording, 2 finished
    int m_stored[2];    // samples stored in this capture (unbounded)
    int m_acc[2];       // samples accepted in this capture
    int m_mem[2][128];
    bit m_wr[2][128];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string id_name(int id);
        string n[6] = '{"read_data", "busy", "done", "write_count", "write_ptr", "sample_ready"};
        return {(id < 6) ? "A." : "B.", n[id % 6]};
    endfunction

    function automatic logic [31:0] get_act(int id);
        case (id)
            0:  return {22'd0, rd_a};
            1:  return {31'd0, busy_a};
            2:  return {31'd0, done_a};
            3:  return {24'd0, cnt_a};
            4:  return {25'd0, ptr_a};
            5:  return {31'd0, ready_a};
            6:  return {22'd0, rd_b};
            7:  return {31'd0, busy_b};
            8:  return {31'd0, done_b};
            9:  return {24'd0, cnt_b};
            10: return {25'd0, ptr_b};
            default: return {31'd0, ready_b};
        endcase
    endfunction

    task automatic push(int id, int exp);
        item_t it;
        it.due = cyc + 1;
        it.id  = id;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic model_step(int k, bit rn, bit st, bit ab, bit v, int d, int ra);
        int  base;
        int  exp_rd;
        bit  rd_known;
        exp_rd   = rn ? m_mem[k][ra] : 0;
        rd_known = !rn || m_wr[k][ra];
        if (!rn) begin
            m_mode[k] = 0; m_stored[k] = 0; m_acc[k] = 0;
        end else if (m_mode[k] == 1) begin
            if (ab) begin
                m_mode[k] = (WRAP && m_stored[k] != 0) ? 2 : 0;
            end else if (v) begin
                m_acc[k]++;
                if (m_acc[k] % m_dec[k] == 0) begin
                    m_mem[k][m_stored[k] % 128] = d;
                    m_wr[k][m_stored[k] % 128]  = 1'b1;
                    m_stored[k]++;
                    if (!WRAP && m_stored[k] == m_len[k]) m_mode[k] = 2;
                end
            end
        end else if (ab) begin
            m_mode[k] = 0;
        end else if (st) begin
            m_mode[k] = 1; m_stored[k] = 0; m_acc[k] = 0;
        end
        base = k * 6;
        if (rd_known) push(base + 0, exp_rd);
        push(base + 1, int'(m_mode[k] == 1));
        push(base + 2, int'(m_mode[k] == 2));
        push(base + 3, (m_stored[k] > 128) ? 128 : m_stored[k]);
        push(base + 4, m_stored[k] % 128);
        push(base + 5, int'(m_mode[k] == 1));
    endtask

    task automatic drive(bit rn, bit st, bit ab, bit v, int d, int ra);
        rst_n        = rn;
        start        = st;
        abort        = ab;
        sample_valid = v;
        sample_data  = 10'(d);
        read_address = 7'(ra);
        for (int k = 0; k < 2; k++) model_step(k, rn, st, ab, v, d, ra);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation that has come due.
    always @(negedge clk) begin
        item_t       it;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            it  = sb.pop_front();
            act = get_act(it.id);
            n_cmp++;
            if (act !== 32'(it.exp)) begin
                n_bad++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", id_name(it.id), act, it.exp, cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_stored[k] = 0; m_acc[k] = 0;
            for (int a = 0; a < 128; a++) begin
                m_mem[k][a] = 0; m_wr[k][a] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Full-length capture of 0..127, then readback of every address.
        drive(1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 128; i++) drive(1, 0, 0, 1, i, $urandom % 128);
        repeat (3) drive(1, 0, 0, 0, 0, $urandom % 128);
        for (int a = 0; a < 128; a++) drive(1, 0, 0, 0, 0, a);

        // Decimated stream 0x010..0x01F.
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 16; i < 32; i++) drive(1, 0, 0, 1, i, i % 4);
        for (int a = 0; a < 6; a++) drive(1, 0, 0, 0, 0, a);

        // Toggling valid, then abort.
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 24; i++) drive(1, 0, 0, (i % 2) == 0, $urandom % 1024, $urandom % 128);
        drive(1, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);

        // Abort after 5 stored samples with valid high in the abort cycle.
        drive(1, 1, 0, 0, 0, 5);
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 1, 'h100 + i, 5);
        drive(1, 0, 1, 1, 'h3FF, 5);
        drive(1, 0, 0, 0, 0, 5);
        drive(1, 0, 0, 0, 0, 4);
        // Start and abort together from IDLE.
        drive(1, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);

        // Reset mid-capture; array must survive.
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 1, 'h200 + i, i);
        drive(0, 0, 0, 1, 'h2AA, 3);
        for (int a = 0; a < 16; a++) drive(1, 0, 0, 0, 0, a);

        // Long stream 0..199 then abort (circular-buffer case when enabled).
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++) drive(1, 0, 0, 1, i, $urandom % 128);
        drive(1, 0, 1, 0, 0, 72);
        drive(1, 0, 0, 0, 0, 71);
        for (int a = 0; a < 128; a++) drive(1, 0, 0, 0, 0, a);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 200) != 0, ($urandom % 16) == 0, ($urandom % 40) == 0,
                  ($urandom % 2) == 0, $urandom % 1024, $urandom % 128);
        end

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
